// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - multi-cycle HI/LO multiply unit: radix-2 shift-add mult/multu with fetch interlock
module hilo_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enhilo_EX,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] A_EX,
    input  logic [XLEN-1:0] B_EX,
    input  logic [1:0]      regsel_EX,
    output logic [XLEN-1:0] hilo_out,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall_FETCH,
    output logic            done
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [3:0] OP_MULT  = 4'b0110;
    localparam logic [3:0] OP_MULTU = 4'b0111;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t            state;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     count;
    logic              op_signed;
    logic              res_neg;

    logic              req_valid;
    logic              req_signed;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] product;

    always_comb begin
        req_valid  = enhilo_EX && (alu_op == OP_MULT || alu_op == OP_MULTU);
        req_signed = (alu_op == OP_MULT);
        // Magnitude of the most negative value wraps to itself, which is its correct unsigned magnitude.
        mag_a = (req_signed && A_EX[XLEN-1]) ? -A_EX : A_EX;
        mag_b = (req_signed && B_EX[XLEN-1]) ? -B_EX : B_EX;
        product = (op_signed && res_neg) ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            op_signed <= 1'b0;
            res_neg   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mcand     <= {{XLEN{1'b0}}, mag_a};
                        mplier    <= mag_b;
                        acc       <= '0;
                        count     <= '0;
                        op_signed <= req_signed;
                        res_neg   <= req_signed && (A_EX[XLEN-1] ^ B_EX[XLEN-1]);
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    hi_reg <= product[2*XLEN-1:XLEN];
                    lo_reg <= product[XLEN-1:0];
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state == CALC) || (state == SIGN);
        stall_FETCH = busy && (enhilo_EX || (regsel_EX != 2'd0));
        hi          = hi_reg;
        lo          = lo_reg;
        case (regsel_EX)
            2'd1:    hilo_out = hi_reg;
            2'd2:    hilo_out = lo_reg;
            default: hilo_out = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enhilo_EX;
    logic [3:0]  alu_op;
    logic [31:0] A_EX;
    logic [31:0] B_EX;
    logic [1:0]  regsel_EX;
    logic [31:0] hilo_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_FETCH;
    logic        done;

    int checks = 0;
    int errors = 0;

    hilo_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .enhilo_EX   (enhilo_EX),
        .alu_op      (alu_op),
        .A_EX        (A_EX),
        .B_EX        (B_EX),
        .regsel_EX   (regsel_EX),
        .hilo_out    (hilo_out),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall_FETCH (stall_FETCH),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one accepting edge, then withdraw it.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        enhilo_EX = 1'b1;
        alu_op    = op;
        A_EX      = a;
        B_EX      = b;
        step();
        enhilo_EX = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Runs the 32 busy cycles following acceptance, then lands in the done cycle.
    task automatic finish_op(input string tag, input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit hold_sel);
        for (int i = 1; i <= 32; i++) begin
            if (hold_sel && i == 4) regsel_EX = 2'd1;
            step();
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done_low"}, 32'(done), 32'd0);
            check({tag, "_hi_hold"}, hi, old_hi);
            check({tag, "_lo_hold"}, lo, old_lo);
            check({tag, "_stall"}, 32'(stall_FETCH), (regsel_EX != 2'd0) ? 32'd1 : 32'd0);
        end
        step();
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (hold_sel) begin
            check({tag, "_stall_done"}, 32'(stall_FETCH), 32'd0);
            check({tag, "_hilo_out_hi"}, hilo_out, exp_hi);
            regsel_EX = 2'd2;
            #1;
            check({tag, "_hilo_out_lo"}, hilo_out, exp_lo);
            regsel_EX = 2'd0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        enhilo_EX = 1'b0;
        alu_op    = 4'd0;
        A_EX      = '0;
        B_EX      = '0;
        regsel_EX = 2'd0;
        step();
        step();
        rst = 1'b0;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_stall", 32'(stall_FETCH), 32'd0);
        check("reset_hilo_out", hilo_out, 32'h0);

        start_op(4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu_max", 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        step();
        check("multu_max_done_pulse", 32'(done), 32'd0);

        start_op(4'b0110, 32'hFFFFFFFD, 32'h00000005);
        finish_op("mult_neg3x5", 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        // Back-to-back request issued in the done cycle.
        start_op(4'b0111, 32'hFFFFFFFD, 32'h00000005);
        finish_op("multu_neg3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000004, 32'hFFFFFFF1, 1'b0);

        start_op(4'b0110, 32'h80000000, 32'h80000000);
        finish_op("mult_min_sq", 32'h00000004, 32'hFFFFFFF1, 32'h40000000, 32'h00000000, 1'b1);

        start_op(4'b0110, 32'h80000000, 32'h00000001);
        finish_op("mult_min_x1", 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        step();

        enhilo_EX = 1'b1;
        alu_op    = 4'b0100;
        A_EX      = 32'h12345678;
        B_EX      = 32'h9ABCDEF0;
        step();
        step();
        enhilo_EX = 1'b0;
        check("bad_op_busy", 32'(busy), 32'd0);
        check("bad_op_hi", hi, 32'hFFFFFFFF);
        check("bad_op_lo", lo, 32'h80000000);

        start_op(4'b0111, 32'h00000007, 32'h00000009);
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", hi, 32'h0);
        check("mid_rst_lo", lo, 32'h0);
        for (int i = 0; i < 30; i++) begin
            check("mid_rst_no_done", 32'(done), 32'd0);
            step();
        end

        rst       = 1'b1;
        enhilo_EX = 1'b1;
        alu_op    = 4'b0110;
        A_EX      = 32'h00000003;
        B_EX      = 32'h00000003;
        step();
        rst       = 1'b0;
        enhilo_EX = 1'b0;
        check("rst_priority_busy", 32'(busy), 32'd0);

        start_op(4'b0110, 32'h00012345, 32'hFFFFFFFE);
        finish_op("after_rst", 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFDB976, 1'b0);
        step();
        check("after_rst_done_pulse", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
